// File: rtl/mixer_seq_pkg.sv
// rtl/mixer_seq_pkg.sv - register map, state codes and helpers for the mixer sequencer
package mixer_seq_pkg;

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_SETTLE = 8'h04;
  localparam logic [7:0] OFF_DWELL  = 8'h08;
  localparam logic [7:0] OFF_CHMASK = 8'h0C;
  localparam logic [7:0] OFF_STATUS = 8'h10;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_ABORT_BIT = 1;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_PWRUP     = 3'd1;
  localparam logic [2:0] ST_CH_SETTLE = 3'd2;
  localparam logic [2:0] ST_SAMPLE    = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_DONE      = 1;
  localparam int STAT_ABORTED   = 2;
  localparam int STAT_CH_LSB    = 4;
  localparam int STAT_STATE_LSB = 8;

  function automatic logic [31:0] apply_sel(input logic [31:0] old_v, input logic [31:0] new_v,
                                            input logic [3:0] sel);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return r;
  endfunction

  // Returns {found, index} of the lowest set mask bit at or above 'from'.
  function automatic logic [3:0] next_set(input logic [7:0] mask, input logic [3:0] from);
    logic [3:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i] && (4'(i) >= from)) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

endpackage

// File: rtl/mixer_seq_wb_regs.sv
// rtl/mixer_seq_wb_regs.sv - Wishbone slave decode and configuration registers
module mixer_seq_wb_regs
  import mixer_seq_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          NCH       = 4,
  parameter int          CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wbs_stb_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  output logic             start_o,
  output logic             abort_o,
  output logic [CNT_W-1:0] settle_o,
  output logic [CNT_W-1:0] dwell_o,
  output logic [NCH-1:0]   chmask_o,
  input  logic [31:0]      status_i
);

  logic             ack_q, ack_d;
  logic [31:0]      dat_q, dat_d;
  logic [CNT_W-1:0] settle_q, settle_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic [NCH-1:0]   chmask_q, chmask_d;
  logic [7:0]       off;
  logic             req, wr, rd;
  logic [31:0]      rdata;

  assign off = wbs_adr_i[7:0];
  // Gating with ack_q keeps a held strobe from being taken twice.
  assign req = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]) & ~ack_q;
  assign wr  = req & wbs_we_i;
  assign rd  = req & ~wbs_we_i;

  assign start_o = wr && (off == OFF_CTRL) && wbs_sel_i[0] && wbs_dat_i[CTRL_START_BIT];
  assign abort_o = wr && (off == OFF_CTRL) && wbs_sel_i[0] && wbs_dat_i[CTRL_ABORT_BIT];

  always_comb begin
    settle_d = settle_q;
    dwell_d  = dwell_q;
    chmask_d = chmask_q;
    if (wr) begin
      case (off)
        OFF_SETTLE: settle_d = CNT_W'(apply_sel(32'(settle_q), wbs_dat_i, wbs_sel_i));
        OFF_DWELL:  dwell_d  = CNT_W'(apply_sel(32'(dwell_q), wbs_dat_i, wbs_sel_i));
        OFF_CHMASK: chmask_d = NCH'(apply_sel(32'(chmask_q), wbs_dat_i, wbs_sel_i));
        default:    ;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    case (off)
      OFF_SETTLE: rdata = 32'(settle_q);
      OFF_DWELL:  rdata = 32'(dwell_q);
      OFF_CHMASK: rdata = 32'(chmask_q);
      OFF_STATUS: rdata = status_i;
      default:    rdata = '0;
    endcase
    ack_d = req;
    dat_d = rd ? rdata : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      settle_q <= CNT_W'(100);
      dwell_q  <= CNT_W'(10);
      chmask_q <= '1;
    end else begin
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      settle_q <= settle_d;
      dwell_q  <= dwell_d;
      chmask_q <= chmask_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign settle_o  = settle_q;
  assign dwell_o   = dwell_q;
  assign chmask_o  = chmask_q;

endmodule

// File: rtl/mixer_seq_ctrl.sv
// rtl/mixer_seq_ctrl.sv - LO power-up, per-channel settle and sample sequencer
module mixer_seq_ctrl
  import mixer_seq_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          NCH       = 4,
  parameter int          CNT_W     = 16
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_ni,
  input  logic           wbs_stb_i,
  input  logic           wbs_cyc_i,
  input  logic           wbs_we_i,
  input  logic [3:0]     wbs_sel_i,
  input  logic [31:0]    wbs_adr_i,
  input  logic [31:0]    wbs_dat_i,
  output logic           wbs_ack_o,
  output logic [31:0]    wbs_dat_o,
  output logic           lo_en_o,
  output logic [NCH-1:0] mix_en_o,
  output logic           sample_o,
  output logic           irq_o
);

  logic             start_p, abort_p;
  logic [CNT_W-1:0] settle, dwell;
  logic [NCH-1:0]   chmask;
  logic [31:0]      status;
  logic [7:0]       mask8;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       ch_q, ch_d;
  logic [CNT_W-1:0] lat_settle_q, lat_settle_d;
  logic [CNT_W-1:0] lat_dwell_q, lat_dwell_d;
  logic [7:0]       lat_mask_q, lat_mask_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic             abort_irq_q, abort_irq_d;
  logic             active, busy;
  logic [3:0]       nxt_first, nxt_after;

  mixer_seq_wb_regs #(.BASE_ADDR(BASE_ADDR), .NCH(NCH), .CNT_W(CNT_W)) u_regs (
    .clk_i     (wb_clk_i),
    .rst_ni    (wb_rst_ni),
    .wbs_stb_i (wbs_stb_i),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o),
    .start_o   (start_p),
    .abort_o   (abort_p),
    .settle_o  (settle),
    .dwell_o   (dwell),
    .chmask_o  (chmask),
    .status_i  (status)
  );

  // A programmed length of 0 behaves as 1; counters run down to 0.
  function automatic logic [CNT_W-1:0] load_of(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - CNT_W'(1);
  endfunction

  always_comb begin
    mask8 = '0;
    mask8[NCH-1:0] = chmask;
  end

  assign active    = (state_q == ST_PWRUP) || (state_q == ST_CH_SETTLE) || (state_q == ST_SAMPLE);
  assign busy      = (state_q != ST_IDLE);
  assign nxt_first = next_set(lat_mask_q, 4'd0);
  assign nxt_after = next_set(lat_mask_q, {1'b0, ch_q} + 4'd1);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ch_d         = ch_q;
    lat_settle_d = lat_settle_q;
    lat_dwell_d  = lat_dwell_q;
    lat_mask_d   = lat_mask_q;
    done_d       = done_q;
    aborted_d    = aborted_q;
    abort_irq_d  = 1'b0;
    // DONE is not abortable: its completion irq is already on the wire.
    if (abort_p && active) begin
      state_d     = ST_IDLE;
      aborted_d   = 1'b1;
      abort_irq_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_p && !abort_p) begin
            lat_settle_d = settle;
            lat_dwell_d  = dwell;
            lat_mask_d   = mask8;
            done_d       = 1'b0;
            aborted_d    = 1'b0;
            cnt_d        = load_of(settle);
            state_d      = ST_PWRUP;
          end
        end
        ST_PWRUP: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else if (nxt_first[3]) begin
            ch_d    = nxt_first[2:0];
            cnt_d   = load_of(lat_settle_q);
            state_d = ST_CH_SETTLE;
          end else begin
            state_d = ST_DONE;
          end
        end
        ST_CH_SETTLE: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            cnt_d   = load_of(lat_dwell_q);
            state_d = ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else if (nxt_after[3]) begin
            ch_d    = nxt_after[2:0];
            cnt_d   = load_of(lat_settle_q);
            state_d = ST_CH_SETTLE;
          end else begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      ch_q         <= '0;
      lat_settle_q <= '0;
      lat_dwell_q  <= '0;
      lat_mask_q   <= '0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      abort_irq_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ch_q         <= ch_d;
      lat_settle_q <= lat_settle_d;
      lat_dwell_q  <= lat_dwell_d;
      lat_mask_q   <= lat_mask_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      abort_irq_q  <= abort_irq_d;
    end
  end

  // Outputs decode straight from state so an async reset drops them at once.
  assign lo_en_o  = active;
  assign mix_en_o = ((state_q == ST_CH_SETTLE) || (state_q == ST_SAMPLE)) ? (NCH'(1) << ch_q) : '0;
  assign sample_o = (state_q == ST_SAMPLE);
  assign irq_o    = (state_q == ST_DONE) || abort_irq_q;

  always_comb begin
    status                           = '0;
    status[STAT_BUSY]                = busy;
    status[STAT_DONE]                = done_q;
    status[STAT_ABORTED]             = aborted_q;
    status[STAT_CH_LSB +: 3]         = ch_q;
    status[STAT_STATE_LSB +: 3]      = state_q;
  end

endmodule

// File: tb/tb_mixer_seq_ctrl.sv
// tb/tb_mixer_seq_ctrl.sv - self-checking bench for mixer_seq_ctrl
module tb_mixer_seq_ctrl;
  localparam int NCH = 4;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic clk = 1'b0, rst_n = 1'b0;
  logic stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0] sel = '0;
  logic [31:0] adr = '0, wdat = '0;
  logic ack;
  logic [31:0] rdat;
  logic lo_en, sample, irq;
  logic [NCH-1:0] mix_en;

  always #5 clk = ~clk;

  mixer_seq_ctrl #(.BASE_ADDR(BASE), .NCH(NCH), .CNT_W(16)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .lo_en_o(lo_en), .mix_en_o(mix_en), .sample_o(sample), .irq_o(irq)
  );

  typedef struct packed {
    logic lo; logic [NCH-1:0] mix; logic smp; logic irq; logic [2:0] st;
  } exp_t;

  exp_t exp_q[$];
  logic [2:0] cur_st = 3'd0;
  int n_checks = 0, n_errors = 0;
  int obs_lo = 0, obs_mix = 0, obs_smp = 0, obs_irq = 0;
  logic [15:0] m_settle = 16'd100, m_dwell = 16'd10;
  logic [NCH-1:0] m_mask = '1;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic lo, input logic [NCH-1:0] mix, input logic smp,
                              input logic irq_v, input logic [2:0] st);
    exp_t e;
    e.lo = lo; e.mix = mix; e.smp = smp; e.irq = irq_v; e.st = st;
    return e;
  endfunction

  // Whole expected output timeline of one run, one entry per clock cycle.
  task automatic push_run(input logic [15:0] s, input logic [15:0] d, input logic [NCH-1:0] m);
    int es, ed;
    logic [NCH-1:0] oh;
    es = (s == 16'd0) ? 1 : int'(s);
    ed = (d == 16'd0) ? 1 : int'(d);
    for (int k = 0; k < es; k++) exp_q.push_back(mk(1'b1, '0, 1'b0, 1'b0, 3'd1));
    for (int i = 0; i < NCH; i++) begin
      if (m[i]) begin
        oh = '0;
        oh[i] = 1'b1;
        for (int k = 0; k < es; k++) exp_q.push_back(mk(1'b1, oh, 1'b0, 1'b0, 3'd2));
        for (int k = 0; k < ed; k++) exp_q.push_back(mk(1'b1, oh, 1'b1, 1'b0, 3'd3));
      end
    end
    exp_q.push_back(mk(1'b0, '0, 1'b0, 1'b1, 3'd4));
  endtask

  task automatic model_write(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s);
    case (off)
      8'h00: if (s[0]) begin
        if (d[1]) begin
          if (cur_st inside {3'd1, 3'd2, 3'd3}) begin
            exp_q.delete();
            exp_q.push_back(mk(1'b0, '0, 1'b0, 1'b1, 3'd0));
          end
        end else if (d[0] && cur_st == 3'd0) begin
          push_run(m_settle, m_dwell, m_mask);
        end
      end
      8'h04: for (int b = 0; b < 2; b++) if (s[b]) m_settle[b*8 +: 8] = d[b*8 +: 8];
      8'h08: for (int b = 0; b < 2; b++) if (s[b]) m_dwell[b*8 +: 8] = d[b*8 +: 8];
      8'h0C: if (s[0]) m_mask = d[NCH-1:0];
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && chk_en) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      cur_st = e.st;
      chk("outputs", {25'd0, lo_en, mix_en, sample, irq}, {25'd0, e.lo, e.mix, e.smp, e.irq});
      obs_lo  += int'(lo_en);
      obs_mix += int'(mix_en != '0);
      obs_smp += int'(sample);
      obs_irq += int'(irq);
    end
  end

  task automatic clear_obs();
    obs_lo = 0; obs_mix = 0; obs_smp = 0; obs_irq = 0;
  endtask

  task automatic wb_write(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s);
    bit got;
    got = 1'b0;
    @(negedge clk);
    adr = BASE | 32'(off); wdat = d; sel = s; we = 1'b1; stb = 1'b1; cyc = 1'b1;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk); #1;
      got = ack;
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    chk("write_ack", 32'(got), 32'd1);
    if (got) model_write(off, d, s);
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] d, output bit got);
    got = 1'b0;
    d = '0;
    @(negedge clk);
    adr = a; sel = 4'hF; we = 1'b0; stb = 1'b1; cyc = 1'b1;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk); #1;
      got = ack;
      d = rdat;
    end
    stb = 1'b0; cyc = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk("run_completes", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    bit got, found;

    repeat (3) @(negedge clk);
    chk("reset_outputs", {25'd0, lo_en, mix_en, sample, irq}, 32'd0);
    chk("reset_ack", {31'd0, ack}, 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    wb_read(BASE | 32'h04, d, got); chk("rd_settle_rst", d, 32'd100);
    wb_read(BASE | 32'h08, d, got); chk("rd_dwell_rst", d, 32'd10);
    wb_read(BASE | 32'h0C, d, got); chk("rd_chmask_rst", d, 32'hF);
    wb_read(BASE | 32'h10, d, got); chk("rd_status_rst", d, 32'd0);
    wb_read(BASE | 32'h14, d, got); chk("rd_unmapped", d, 32'd0); chk("rd_unmapped_ack", 32'(got), 32'd1);
    wb_read(32'h3000_0104, d, got); chk("no_ack_other_base", 32'(got), 32'd0);

    wb_write(8'h04, 32'h0000_1234, 4'b0001);
    wb_read(BASE | 32'h04, d, got); chk("byte_lane", d, 32'h34);
    wb_write(8'h14, 32'hFFFF_FFFF, 4'hF);
    wb_read(BASE | 32'h08, d, got); chk("unmapped_write_ignored", d, 32'd10);

    // Two channels, settle 3, dwell 2.
    wb_write(8'h04, 32'd3, 4'hF);
    wb_write(8'h08, 32'd2, 4'hF);
    wb_write(8'h0C, 32'h5, 4'hF);
    clear_obs();
    wb_write(8'h00, 32'h1, 4'hF);
    wait_idle(200);
    chk("run1_lo_cycles", obs_lo, 13);
    chk("run1_mix_cycles", obs_mix, 10);
    chk("run1_sample_cycles", obs_smp, 4);
    chk("run1_irq_cycles", obs_irq, 1);
    wb_read(BASE | 32'h10, d, got); chk("run1_status_flags", d & 32'h7, 32'h2);

    // Empty mask: power-up only.
    wb_write(8'h0C, 32'h0, 4'hF);
    clear_obs();
    wb_write(8'h00, 32'h1, 4'hF);
    wait_idle(200);
    chk("empty_lo_cycles", obs_lo, 3);
    chk("empty_mix_cycles", obs_mix, 0);
    chk("empty_irq_cycles", obs_irq, 1);

    // Zero lengths behave as one cycle.
    wb_write(8'h04, 32'd0, 4'hF);
    wb_write(8'h08, 32'd0, 4'hF);
    wb_write(8'h0C, 32'hA, 4'hF);
    clear_obs();
    wb_write(8'h00, 32'h1, 4'hF);
    wait_idle(200);
    chk("zero_len_lo_cycles", obs_lo, 5);
    chk("zero_len_sample_cycles", obs_smp, 2);

    // START with ABORT in IDLE: abort wins, nothing starts, done stays set.
    clear_obs();
    wb_write(8'h00, 32'h3, 4'hF);
    repeat (4) @(negedge clk);
    chk("start_abort_idle_lo", obs_lo, 0);
    wb_read(BASE | 32'h10, d, got); chk("start_abort_idle_status", d & 32'h707, 32'h2);

    // Abort during SAMPLE on channel 2.
    wb_write(8'h04, 32'd2, 4'hF);
    wb_write(8'h08, 32'd6, 4'hF);
    wb_write(8'h0C, 32'h5, 4'hF);
    clear_obs();
    wb_write(8'h00, 32'h1, 4'hF);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      found = sample && (mix_en == 4'b0100);
    end
    chk("reach_ch2_sample", 32'(found), 32'd1);
    wb_write(8'h00, 32'h2, 4'hF);
    repeat (3) @(negedge clk);
    chk("abort_irq_cycles", obs_irq, 1);
    wb_read(BASE | 32'h10, d, got); chk("abort_status_flags", d & 32'h7, 32'h4);

    // Writes while busy leave the running sequence alone.
    wb_write(8'h04, 32'd3, 4'hF);
    wb_write(8'h08, 32'd2, 4'hF);
    clear_obs();
    wb_write(8'h00, 32'h1, 4'hF);
    repeat (3) @(negedge clk);
    wb_write(8'h04, 32'd50, 4'hF);
    wb_write(8'h00, 32'h1, 4'hF);
    wait_idle(200);
    chk("busy_write_lo_cycles", obs_lo, 13);
    chk("busy_write_irq_cycles", obs_irq, 1);
    wb_write(8'h0C, 32'h1, 4'hF);
    clear_obs();
    wb_write(8'h00, 32'h1, 4'hF);
    wait_idle(400);
    chk("settle50_lo_cycles", obs_lo, 102);
    chk("settle50_sample_cycles", obs_smp, 2);

    // Asynchronous reset in CH_SETTLE.
    wb_write(8'h04, 32'd5, 4'hF);
    wb_write(8'h00, 32'h1, 4'hF);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      found = (mix_en != '0);
    end
    chk("reach_ch_settle", 32'(found), 32'd1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    cur_st = 3'd0;
    m_settle = 16'd100; m_dwell = 16'd10; m_mask = '1;
    #1;
    chk("async_reset_outputs", {25'd0, lo_en, mix_en, sample, irq}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    wb_read(BASE | 32'h10, d, got); chk("post_reset_status", d, 32'd0);
    wb_read(BASE | 32'h04, d, got); chk("post_reset_settle", d, 32'd100);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
